// File: rtl/cdb_arbiter.sv
// Two-slot common data bus arbiter: round-robin picks up to two ready results
// per cycle and broadcasts them from registered CDB slots one cycle later.

module cdb_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         vld_d,
  input  logic [W-1:0] pkt_d,
  output logic         vld_q,
  output logic [W-1:0] pkt_q
);
  // Invalid slots broadcast zeros so register-match consumers never see stale tags.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      pkt_q <= '0;
    end else begin
      vld_q <= vld_d;
      pkt_q <= vld_d ? pkt_d : '0;
    end
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = 32,
  parameter int ARN_W   = 5,
  parameter int RRN_W   = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ARN_W-1:0]   req_arn,
  input  logic [NUM_REQ-1:0][RRN_W-1:0]   req_rrn,
  input  logic [NUM_REQ-1:0][XLEN-1:0]    req_result,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [1:0]                      cdb_valid,
  output logic [1:0][ARN_W-1:0]           cdb_arn,
  output logic [1:0][RRN_W-1:0]           cdb_rrn,
  output logic [1:0][XLEN-1:0]            cdb_result
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic [ARN_W-1:0] arn;
    logic [RRN_W-1:0] rrn;
    logic [XLEN-1:0]  result;
  } cdb_pkt_t;

  localparam int PKT_W = $bits(cdb_pkt_t);

  logic [PTR_W-1:0] ptr, ptr_nxt, scan_idx, g0, g1;
  logic             g0_hit, g1_hit, gate;
  logic [1:0]       slot_vld;
  cdb_pkt_t [1:0]   slot_d, slot_q;

  // Cyclic scan from ptr: first valid requester -> slot 0, second -> slot 1.
  always_comb begin
    g0       = '0;
    g1       = '0;
    g0_hit   = 1'b0;
    g1_hit   = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        if (!g0_hit) begin
          g0_hit = 1'b1;
          g0     = scan_idx;
        end else if (!g1_hit) begin
          g1_hit = 1'b1;
          g1     = scan_idx;
        end
      end
    end
  end

  assign gate = !reset && !flush;

  always_comb begin
    req_ready = '0;
    slot_vld  = '0;
    slot_d    = '0;
    ptr_nxt   = ptr;
    if (gate && g0_hit) begin
      req_ready[g0]    = 1'b1;
      slot_vld[0]      = 1'b1;
      slot_d[0].arn    = req_arn[g0];
      slot_d[0].rrn    = req_rrn[g0];
      slot_d[0].result = req_result[g0];
      if (g1_hit) begin
        req_ready[g1]    = 1'b1;
        slot_vld[1]      = 1'b1;
        slot_d[1].arn    = req_arn[g1];
        slot_d[1].rrn    = req_rrn[g1];
        slot_d[1].result = req_result[g1];
      end
      ptr_nxt = PTR_W'(((g1_hit ? int'(g1) : int'(g0)) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else       ptr <= ptr_nxt;
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    cdb_slot #(.W(PKT_W)) u_slot (
      .clk   (clk),
      .reset (reset),
      .vld_d (slot_vld[s]),
      .pkt_d (slot_d[s]),
      .vld_q (cdb_valid[s]),
      .pkt_q (slot_q[s])
    );
    assign cdb_arn[s]    = slot_q[s].arn;
    assign cdb_rrn[s]    = slot_q[s].rrn;
    assign cdb_result[s] = slot_q[s].result;
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized traffic against a
// queue-based round-robin reference model.

module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int XL = 32;
  localparam int AW = 5;
  localparam int RW = 6;

  logic clk = 1'b0;
  logic reset, flush;
  logic [N-1:0]          req_valid, req_ready;
  logic [N-1:0][AW-1:0]  req_arn;
  logic [N-1:0][RW-1:0]  req_rrn;
  logic [N-1:0][XL-1:0]  req_result;
  logic [1:0]            cdb_valid;
  logic [1:0][AW-1:0]    cdb_arn;
  logic [1:0][RW-1:0]    cdb_rrn;
  logic [1:0][XL-1:0]    cdb_result;

  int checks = 0;
  int errors = 0;

  // reference model state and per-cycle expectations
  int                   m_ptr, m_ptr_nxt;
  logic [N-1:0]         m_ready;
  logic [1:0]           m_vld;
  logic [1:0][AW-1:0]   m_arn;
  logic [1:0][RW-1:0]   m_rrn;
  logic [1:0][XL-1:0]   m_res;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .XLEN(XL), .ARN_W(AW), .RRN_W(RW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_arn(req_arn), .req_rrn(req_rrn), .req_result(req_result),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_arn(cdb_arn), .cdb_rrn(cdb_rrn), .cdb_result(cdb_result)
  );

  // Collect valid requesters in cyclic order from ptr; the first two win.
  task automatic model_eval();
    int q[$];
    m_ready = '0; m_vld = '0; m_arn = '0; m_rrn = '0; m_res = '0;
    m_ptr_nxt = m_ptr;
    if (reset) begin
      m_ptr_nxt = 0;
    end else if (!flush) begin
      for (int k = 0; k < N; k++)
        if (req_valid[(m_ptr + k) % N]) q.push_back((m_ptr + k) % N);
      for (int s = 0; s < 2 && s < q.size(); s++) begin
        m_ready[q[s]] = 1'b1;
        m_vld[s] = 1'b1;
        m_arn[s] = req_arn[q[s]];
        m_rrn[s] = req_rrn[q[s]];
        m_res[s] = req_result[q[s]];
      end
      if (q.size() > 0) m_ptr_nxt = (q[(q.size() > 1) ? 1 : 0] + 1) % N;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    m_ptr = m_ptr_nxt;
  endtask

  task automatic rand_data();
    for (int i = 0; i < N; i++) begin
      req_arn[i]    = AW'($urandom);
      req_rrn[i]    = RW'($urandom);
      req_result[i] = $urandom;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; req_valid = '1;
    for (int c = 0; c < 2; c++) begin
      rand_data(); model_eval(); #1;
      checks++;
      if (req_ready !== '0) begin
        errors++; $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      tick();
      checks++;
      if ({cdb_valid, cdb_arn, cdb_rrn, cdb_result} !== '0) begin
        errors++;
        $display("FAIL reset_cdb: got v=%b arn=%h rrn=%h res=%h want all zero",
                 cdb_valid, cdb_arn, cdb_rrn, cdb_result);
      end
    end
    reset = 1'b0; req_valid = '0;
  endtask

  task automatic test_all_valid();
    logic [N-1:0] exp_ready [2];
    exp_ready[0] = 4'b0011; exp_ready[1] = 4'b1100;
    for (int c = 0; c < 2; c++) begin
      req_valid = '1; rand_data(); model_eval(); #1;
      checks++;
      if (req_ready !== exp_ready[c] || req_ready !== m_ready) begin
        errors++; $display("FAIL all_valid_ready[%0d]: got %b want %b", c, req_ready, exp_ready[c]);
      end
      tick();
      checks++;
      if ({cdb_valid, cdb_arn, cdb_rrn, cdb_result} !== {2'b11, m_arn, m_rrn, m_res}) begin
        errors++;
        $display("FAIL all_valid_cdb[%0d]: got v=%b arn=%h rrn=%h res=%h want v=11 arn=%h rrn=%h res=%h",
                 c, cdb_valid, cdb_arn, cdb_rrn, cdb_result, m_arn, m_rrn, m_res);
      end
    end
    checks++;
    if (m_ptr != 0) begin
      errors++; $display("FAIL all_valid_ptr: model ptr %0d want 0", m_ptr);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    rand_data();
    req_valid = 4'b0100;
    req_arn[2] = 5'd7; req_rrn[2] = 6'd33; req_result[2] = 32'hDEADBEEF;
    model_eval(); #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_arn[0] !== 5'd7 || cdb_rrn[0] !== 6'd33 ||
        cdb_result[0] !== 32'hDEADBEEF || cdb_arn[1] !== '0 || cdb_rrn[1] !== '0 ||
        cdb_result[1] !== '0) begin
      errors++;
      $display("FAIL single_cdb: got v=%b arn=%h rrn=%h res=%h want v=01 slot0 7/33/deadbeef slot1 0",
               cdb_valid, cdb_arn, cdb_rrn, cdb_result);
    end
    // idle cycle: the broadcast must not persist
    req_valid = '0; model_eval(); tick();
    checks++;
    if ({cdb_valid, cdb_arn, cdb_rrn, cdb_result} !== '0) begin
      errors++;
      $display("FAIL single_expire: got v=%b arn=%h rrn=%h res=%h want all zero",
               cdb_valid, cdb_arn, cdb_rrn, cdb_result);
    end
  endtask

  task automatic test_wrap();
    rand_data(); req_valid = 4'b1001; model_eval(); #1;
    checks++;
    if (req_ready !== 4'b1001) begin
      errors++; $display("FAIL wrap_ready: got %b want 1001", req_ready);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_arn[0] !== req_arn[3] || cdb_rrn[0] !== req_rrn[3] ||
        cdb_result[0] !== req_result[3] || cdb_arn[1] !== req_arn[0] ||
        cdb_rrn[1] !== req_rrn[0] || cdb_result[1] !== req_result[0]) begin
      errors++;
      $display("FAIL wrap_cdb: got v=%b arn=%h rrn=%h res=%h want slot0=req3 slot1=req0",
               cdb_valid, cdb_arn, cdb_rrn, cdb_result);
    end
    req_valid = '0;
  endtask

  task automatic test_flush();
    rand_data(); req_valid = '1; flush = 1'b1; model_eval(); #1;
    checks++;
    if (req_ready !== '0) begin
      errors++; $display("FAIL flush_ready: got %b want 0000", req_ready);
    end
    tick();
    flush = 1'b0;
    checks++;
    if ({cdb_valid, cdb_arn, cdb_rrn, cdb_result} !== '0) begin
      errors++;
      $display("FAIL flush_cdb: got v=%b arn=%h rrn=%h res=%h want all zero",
               cdb_valid, cdb_arn, cdb_rrn, cdb_result);
    end
    // ptr was 1 before the flush and must still be 1
    rand_data(); model_eval(); #1;
    checks++;
    if (req_ready !== 4'b0110) begin
      errors++; $display("FAIL flush_ptr_hold: got %b want 0110", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    rand_data(); req_valid = '1; model_eval(); tick();
    checks++;
    if (cdb_valid !== 2'b11) begin
      errors++; $display("FAIL mid_pre: got v=%b want 11", cdb_valid);
    end
    reset = 1'b1; rand_data(); model_eval(); tick();
    reset = 1'b0;
    checks++;
    if ({cdb_valid, cdb_arn, cdb_rrn, cdb_result} !== '0) begin
      errors++;
      $display("FAIL mid_reset_cdb: got v=%b arn=%h rrn=%h res=%h want all zero",
               cdb_valid, cdb_arn, cdb_rrn, cdb_result);
    end
    rand_data(); model_eval(); #1;
    checks++;
    if (req_ready !== 4'b0011) begin
      errors++; $display("FAIL mid_ptr_zero: got %b want 0011", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] hold;
    rand_data();
    req_valid = N'($urandom);
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 11) == 0);
      model_eval(); #1;
      checks++;
      if (req_ready !== m_ready) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, m_ready);
      end
      hold = req_valid & ~m_ready;
      tick();
      checks++;
      if ({cdb_valid, cdb_arn, cdb_rrn, cdb_result} !== {m_vld, m_arn, m_rrn, m_res}) begin
        errors++;
        $display("FAIL rand_cdb[%0d]: got v=%b arn=%h rrn=%h res=%h want v=%b arn=%h rrn=%h res=%h",
                 c, cdb_valid, cdb_arn, cdb_rrn, cdb_result, m_vld, m_arn, m_rrn, m_res);
      end
      // ungranted requesters keep their payload; others may offer new data
      for (int i = 0; i < N; i++) begin
        if (!hold[i]) begin
          req_valid[i]  = ($urandom_range(0, 2) != 0);
          req_arn[i]    = AW'($urandom);
          req_rrn[i]    = RW'($urandom);
          req_result[i] = $urandom;
        end
      end
    end
    reset = 1'b0; flush = 1'b0; req_valid = '0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = '0;
    req_arn = '0; req_rrn = '0; req_result = '0;
    m_ptr = 0; m_ptr_nxt = 0;
    @(posedge clk); #1;
    test_reset();
    test_all_valid();
    test_single();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
